// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, fetch-busy bubble,
// data-memory stall tracking with timeout fault.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles counter output.
module pipeline_hazard_ctrl #(
   parameter int unsigned STALL_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_read_reg1,
   input  logic [3:0]  id_read_reg2,
   input  logic        id_uses_reg1,
   input  logic        id_uses_reg2,
   input  logic        idex_memtoreg,
   input  logic        idex_rf_write,
   input  logic [3:0]  idex_write_reg,
   input  logic        branch_taken,
   input  logic        imem_busy,
   input  logic        dmem_busy,
   input  logic        err_clr,
   output logic        pc_wen,
   output logic        ifid_wen,
   output logic        idex_wen,
   output logic        exmem_wen,
   output logic        memwb_wen,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        pc_redirect,
   output logic        imem_cancel,
   output logic [1:0]  state,
`ifdef HAZARD_PERF_CNT_EN
   output logic [15:0] stall_cycles,
`endif
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDstall = 2'd1,
      StFault  = 2'd2
   } state_e;

   localparam logic [15:0] TimeoutLen = 16'(STALL_TIMEOUT);

   state_e      state_q, state_d;
   logic [15:0] stall_len_q, stall_len_d;
   logic        timeout_err_q, timeout_err_d;
   logic        load_use;
   logic        frozen;

   assign load_use = idex_memtoreg & idex_rf_write &
                     ((id_uses_reg1 & (id_read_reg1 == idex_write_reg)) |
                      (id_uses_reg2 & (id_read_reg2 == idex_write_reg)));

   // Hazard resolution outputs, highest priority first: freeze, branch, load-use, fetch busy.
   always_comb begin
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pc_redirect = 1'b0;
      imem_cancel = 1'b0;
      // The unused encoding behaves like FAULT.
      case (state_q)
         StRun, StDstall: frozen = dmem_busy;
         default:         frozen = 1'b1;
      endcase
      if (frozen) begin
         pc_wen    = 1'b0;
         ifid_wen  = 1'b0;
         idex_wen  = 1'b0;
         exmem_wen = 1'b0;
         memwb_wen = 1'b0;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         pc_redirect = 1'b1;
         imem_cancel = imem_busy;
      end else if (load_use) begin
         pc_wen     = 1'b0;
         ifid_wen   = 1'b0;
         idex_flush = 1'b1;
      end else if (imem_busy) begin
         pc_wen     = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   // Next-state logic for the stall/fault FSM and the stall length counter.
   always_comb begin
      state_d       = state_q;
      stall_len_d   = stall_len_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         StRun: begin
            if (dmem_busy) begin
               state_d     = StDstall;
               stall_len_d = 16'd1;
            end
         end
         StDstall: begin
            // Timeout wins over a simultaneous exit.
            if (dmem_busy && (stall_len_q == TimeoutLen)) begin
               state_d       = StFault;
               timeout_err_d = 1'b1;
               stall_len_d   = 16'd0;
            end else if (dmem_busy) begin
               stall_len_d = stall_len_q + 16'd1;
            end else begin
               state_d     = StRun;
               stall_len_d = 16'd0;
            end
         end
         default: begin
            stall_len_d = 16'd0;
            if (err_clr) begin
               state_d       = StRun;
               timeout_err_d = 1'b0;
            end else begin
               state_d = StFault;
            end
         end
      endcase
   end

   // FSM state, stall length and sticky fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         stall_len_q   <= 16'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_len_q   <= stall_len_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign state       = state_q;
   assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;

   // Saturating count of cycles in which the PC did not advance.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_wen && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   // Performance counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 16'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (STALL_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  id_read_reg1 = '0, id_read_reg2 = '0, idex_write_reg = '0;
   logic        id_uses_reg1 = 1'b0, id_uses_reg2 = 1'b0;
   logic        idex_memtoreg = 1'b0, idex_rf_write = 1'b0;
   logic        branch_taken = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0, err_clr = 1'b0;
   logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
   logic        ifid_flush, idex_flush, pc_redirect, imem_cancel;
   logic [1:0]  state;
   logic        timeout_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles;
`endif

   pipeline_hazard_ctrl #(.STALL_TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_read_reg1   (id_read_reg1),
      .id_read_reg2   (id_read_reg2),
      .id_uses_reg1   (id_uses_reg1),
      .id_uses_reg2   (id_uses_reg2),
      .idex_memtoreg  (idex_memtoreg),
      .idex_rf_write  (idex_rf_write),
      .idex_write_reg (idex_write_reg),
      .branch_taken   (branch_taken),
      .imem_busy      (imem_busy),
      .dmem_busy      (dmem_busy),
      .err_clr        (err_clr),
      .pc_wen         (pc_wen),
      .ifid_wen       (ifid_wen),
      .idex_wen       (idex_wen),
      .exmem_wen      (exmem_wen),
      .memwb_wen      (memwb_wen),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .pc_redirect    (pc_redirect),
      .imem_cancel    (imem_cancel),
      .state          (state),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cycles   (stall_cycles),
`endif
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   // Write-enable groups {pc, ifid, idex, exmem, memwb}
   localparam int WAll  = 5'b11111;
   localparam int WNone = 5'b00000;
   localparam int WLu   = 5'b00111;
   localparam int WIb   = 5'b01111;
   // Flush groups {ifid_flush, idex_flush, pc_redirect, imem_cancel}
   localparam int FNone = 4'b0000;
   localparam int FLu   = 4'b0100;
   localparam int FIb   = 4'b1000;
   localparam int FBr   = 4'b1110;
   localparam int FBrC  = 4'b1111;

   typedef struct {
      string       name;
      logic [12:0] exp;
      int          sc;
   } exp_t;

   exp_t sb_q[$];
   int   sc_model = 0;
   bit   stim_done = 1'b0;
   int   total = 0;
   int   bad = 0;

   function automatic logic [12:0] mk(input int w, input int f, input int s, input int t);
      return {5'(w), 4'(f), 2'(s), 1'(t)};
   endfunction

   // One cycle of stimulus; the expected response goes to the scoreboard.
   task automatic cyc(input string nm, input int rr1, input int u1, input int rr2, input int u2,
                      input int wr, input int mtr, input int rfw, input int br, input int ib,
                      input int db, input int ec, input logic [12:0] ex);
      exp_t e;
      @(posedge clk);
      #1;
      id_read_reg1   = 4'(rr1);
      id_uses_reg1   = (u1 != 0);
      id_read_reg2   = 4'(rr2);
      id_uses_reg2   = (u2 != 0);
      idex_write_reg = 4'(wr);
      idex_memtoreg  = (mtr != 0);
      idex_rf_write  = (rfw != 0);
      branch_taken   = (br != 0);
      imem_busy      = (ib != 0);
      dmem_busy      = (db != 0);
      err_clr        = (ec != 0);
      e.name = nm;
      e.exp  = ex;
      e.sc   = sc_model;
      sb_q.push_back(e);
      if (ex[12] == 1'b0) sc_model++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      {id_read_reg1, id_read_reg2, idex_write_reg} = '0;
      {id_uses_reg1, id_uses_reg2, idex_memtoreg, idex_rf_write} = '0;
      {branch_taken, imem_busy, dmem_busy, err_clr} = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sc_model = 0;
   endtask

   // Stimulus: args are rr1,u1,rr2,u2,wr,mtr,rfw,br,ib,db,ec
   initial begin
      do_reset();
      cyc("reset_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("lu_reg2",     0, 0, 3, 1, 3, 1, 1, 0, 0, 0, 0, mk(WLu,   FLu,   0, 0));
      cyc("no_use2",     0, 0, 3, 0, 3, 1, 1, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("lu_reg1",     5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, mk(WLu,   FLu,   0, 0));
      cyc("no_rfwrite",  5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("no_memtoreg", 5, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("reg_differ",  5, 1, 6, 1, 7, 1, 1, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("lu_branch",   0, 0, 3, 1, 3, 1, 1, 1, 0, 0, 0, mk(WAll,  FBr,   0, 0));
      cyc("imem_busy",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, mk(WIb,   FIb,   0, 0));
      cyc("imem_branch", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, mk(WAll,  FBrC,  0, 0));
      cyc("imem_lu",     0, 0, 3, 1, 3, 1, 1, 0, 1, 0, 0, mk(WLu,   FLu,   0, 0));
      // Data stall with a pending branch held through the freeze
      cyc("dfrz_run",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, mk(WNone, FNone, 0, 0));
      cyc("dfrz_st1",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, mk(WNone, FNone, 1, 0));
      cyc("dfrz_st2",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, mk(WNone, FNone, 1, 0));
      cyc("dstall_exit", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, mk(WAll,  FBr,   1, 0));
      cyc("run_branch",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, mk(WAll,  FBr,   0, 0));
      cyc("quiet",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      // Timeout: STALL_TIMEOUT=4, FAULT after the 5th busy edge
      cyc("to_run",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 0, 0));
      cyc("to_len1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 1, 0));
      cyc("to_clr_ign",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(WNone, FNone, 1, 0));
      cyc("to_len3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 1, 0));
      cyc("to_len4",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 1, 0));
      cyc("fault",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 2, 1));
      cyc("fault_hold",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, mk(WNone, FNone, 2, 1));
      cyc("fault_clr",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(WNone, FNone, 2, 1));
      cyc("after_clr",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      // Reset in the middle of a data stall
      cyc("pre_rst_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 0, 0));
      cyc("pre_rst_ds",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 1, 0));
      do_reset();
      cyc("rst_dstall",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      // Reset while in FAULT
      for (int i = 0; i < 5; i++) begin
         cyc("pre_rst_stl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, (i == 0) ? 0 : 1, 0));
      end
      cyc("pre_rst_flt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(WNone, FNone, 2, 1));
      do_reset();
      cyc("rst_fault",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(WAll,  FNone, 0, 0));
      cyc("lu_post_rst", 0, 0, 9, 1, 9, 1, 1, 0, 0, 0, 0, mk(WLu,   FLu,   0, 0));
      stim_done = 1'b1;
   end

   // Monitor: checks each scoreboard entry mid-cycle, then prints the summary.
   initial begin
      exp_t        e;
      logic [12:0] act;
      bit          done = 1'b0;
      for (int cyc_n = 0; cyc_n < 2000 && !done; cyc_n++) begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                   ifid_flush, idex_flush, pc_redirect, imem_cancel, state, timeout_err};
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got %b want %b (wen5,flush4,state2,terr)", e.name, act, e.exp);
            end
`ifdef HAZARD_PERF_CNT_EN
            total++;
            if (stall_cycles !== 16'(e.sc)) begin
               bad++;
               $display("FAIL %s_stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
            end
`endif
         end
         if (stim_done && sb_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL run_timeout: got %0d pending want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 255, meaning the maximum consecutive dmem_busy cycles before fault (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have inputs id_read_reg1 and id_read_reg2, each 4 bits, meaning the source register ids of the instruction in ID.
REQ-005 SHALL have inputs id_uses_reg1 and id_uses_reg2, each 1 bit, meaning the ID instruction actually reads that source.
REQ-006 SHALL have inputs idex_memtoreg and idex_rf_write, each 1 bit, and idex_write_reg, 4 bits, meaning the destination info of the instruction in EX.
REQ-007 SHALL have inputs branch_taken, imem_busy, dmem_busy and err_clr, each 1 bit, meaning EX redirect, fetch not ready, data memory not ready, and fault clear.
REQ-008 SHALL have outputs pc_wen, ifid_wen, idex_wen, exmem_wen and memwb_wen, each 1 bit, driving the PC and pipeline-register write enables.
REQ-009 SHALL have outputs ifid_flush, idex_flush, pc_redirect and imem_cancel, each 1 bit, meaning insert bubble, insert bubble, select branch target, and abort outstanding fetch.
REQ-010 SHALL have outputs state, 2 bits, and timeout_err, 1 bit, meaning the FSM state and the sticky fault flag.

Function
REQ-011 SHALL implement FSM states RUN=2'd0, DSTALL=2'd1 and FAULT=2'd2; 2'd3 is unreachable and SHALL be treated as FAULT.
REQ-012 SHALL assert load_use when idex_memtoreg & idex_rf_write & ((id_uses_reg1 & id_read_reg1==idex_write_reg) | (id_uses_reg2 & id_read_reg2==idex_write_reg)).
REQ-013 SHALL compute all control outputs combinationally from the current state and inputs (zero-cycle latency), evaluating the conditions in the priority order of REQ-014 to REQ-018.
REQ-014 SHALL, when in FAULT, or in RUN/DSTALL with dmem_busy=1, drive all five wen signals to 0 and all flush, redirect and cancel outputs to 0 (freeze).
REQ-015 SHALL, when not frozen and branch_taken=1, drive all wen to 1, ifid_flush=1, idex_flush=1, pc_redirect=1, and imem_cancel equal to imem_busy; this ignores load_use.
REQ-016 SHALL, when not frozen, branch_taken=0 and load_use=1, drive pc_wen=0 and ifid_wen=0, and idex_flush=1 with all other wen at 1.
REQ-017 SHALL, when not frozen, with no branch and no load_use, and imem_busy=1, drive pc_wen=0, ifid_wen=1 and ifid_flush=1 with all other wen at 1.
REQ-018 SHALL otherwise drive all wen to 1 and all flush, redirect and cancel outputs to 0.
REQ-019 SHALL move RUN->DSTALL on dmem_busy=1, DSTALL->RUN on dmem_busy=0, and stay in RUN otherwise.
REQ-020 SHALL maintain a 16-bit stall_len counter: load 1 on RUN->DSTALL, increment each DSTALL cycle with dmem_busy=1, and clear on leaving DSTALL.
REQ-021 SHALL move DSTALL->FAULT and set timeout_err when dmem_busy=1 and stall_len==STALL_TIMEOUT in the same cycle; the timeout check takes priority over the exit condition.
REQ-022 SHALL hold FAULT and timeout_err until err_clr=1, then go to RUN and clear timeout_err on the next edge; err_clr SHALL have no effect outside FAULT.
REQ-023 SHALL keep branch_taken asserted through a freeze with no internal latching, because the EX instruction is held while frozen.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force state=RUN, stall_len=0, timeout_err=0 and stall_cycles=0, overriding all other updates including a mid-stall or FAULT condition.
REQ-025 SHALL drive the outputs from the RUN-state equations on the cycle after reset.

Configuration
REQ-026 SHALL, with macro HAZARD_PERF_CNT_EN defined, add a 16-bit output stall_cycles that counts cycles where pc_wen=0 and saturates at 16'hFFFF.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, omit the stall_cycles port and its counter entirely.

Verification
REQ-028 SHALL test: idex_memtoreg=1, idex_rf_write=1, idex_write_reg=4'h3, id_uses_reg2=1, id_read_reg2=4'h3 -> pc_wen=0, ifid_wen=0, idex_flush=1, exmem_wen=1.
REQ-029 SHALL test: load_use and branch_taken together -> pc_redirect=1, ifid_flush=1, idex_flush=1, pc_wen=1.
REQ-030 SHALL test: dmem_busy high for 3 cycles with branch_taken=1 -> all wen=0 and state=1 for 3 cycles, then RUN with pc_redirect=1.
REQ-031 SHALL test: STALL_TIMEOUT=4 with dmem_busy held -> state=2 and timeout_err=1 after the 5th edge; err_clr pulse -> RUN and timeout_err=0.
REQ-032 SHALL test: imem_busy=1 alone -> pc_wen=0, ifid_flush=1, idex_wen=1; imem_busy with branch_taken -> imem_cancel=1.
REQ-033 SHALL test: rst asserted during DSTALL -> state=0, timeout_err=0, and stall_cycles=0 when HAZARD_PERF_CNT_EN is defined.
